// File: rtl/seq_divider_4bit.sv
// seq_divider_4bit: restoring shift-subtract divider, one quotient bit per clock, unsigned or signed
module seq_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SignedMode,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic             Overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] dvd, dvs, rem, a_mag, b_mag, q_mag, r_mag;
    logic [WIDTH:0] sh, trial;
    logic [CW-1:0] cnt;
    logic q_neg, r_neg, ovf, b_zero;
    always_comb begin
        a_mag = SignedMode && A[WIDTH-1] ? -A : A;
        b_mag = SignedMode && B[WIDTH-1] ? -B : B;
        b_zero = B == '0;
        sh = {rem, dvd[WIDTH-1]};
        trial = sh - {1'b0, dvs};
        q_mag = {dvd[WIDTH-2:0], ~trial[WIDTH]};
        r_mag = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            Quotient <= '0;
            Remainder <= '0;
            Busy <= 1'b0;
            Done <= 1'b0;
            DivZero <= 1'b0;
            Overflow <= 1'b0;
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            ovf <= 1'b0;
        end else if (state != RUN) begin
            if (Start) begin
                state <= b_zero ? DONE : RUN;
                Busy <= !b_zero;
                Done <= b_zero;
                DivZero <= b_zero;
                Overflow <= 1'b0;
                if (b_zero) begin
                    Quotient <= '1;
                    Remainder <= A;
                end
                dvd <= a_mag;
                dvs <= b_mag;
                rem <= '0;
                cnt <= '0;
                q_neg <= SignedMode && (A[WIDTH-1] ^ B[WIDTH-1]);
                r_neg <= SignedMode && A[WIDTH-1];
                ovf <= SignedMode && A == {1'b1, {(WIDTH-1){1'b0}}} && B == '1;
            end
        end else begin
            dvd <= q_mag;
            rem <= r_mag;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
                state <= DONE;
                Busy <= 1'b0;
                Done <= 1'b1;
                Overflow <= ovf;
                Quotient <= q_neg ? -q_mag : q_mag;
                Remainder <= r_neg ? -r_mag : r_mag;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider_4bit.sv
// tb_seq_divider_4bit: random and directed divides, scoreboard of integer-arithmetic expectations
module tb_seq_divider_4bit;
    logic clk = 0, rst = 1, Start = 0, SignedMode = 0;
    logic [3:0] A = 0, B = 0;
    logic [3:0] Quotient, Remainder;
    logic Busy, Done, DivZero, Overflow;
    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic dz;
        logic ov;
        int due;
    } exp_t;
    exp_t sb[$];
    exp_t held;
    int n_chk = 0, n_fail = 0, cyc = 0, run_left = 0;
    logic prev_start = 0, prev_done = 0;

    seq_divider_4bit dut (
        .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .SignedMode(SignedMode),
        .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy), .Done(Done),
        .DivZero(DivZero), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic s, input int due);
        exp_t e;
        int ai, bi, qi, ri;
        e.due = due;
        e.dz = (b == 0);
        e.ov = 0;
        if (b == 0) begin
            e.q = 4'hf;
            e.r = a;
        end else begin
            ai = s ? int'($signed(a)) : int'(a);
            bi = s ? int'($signed(b)) : int'(b);
            qi = ai / bi;
            ri = ai % bi;
            e.q = qi[3:0];
            e.r = ri[3:0];
            e.ov = s && ai == -8 && bi == -1;
        end
        return e;
    endfunction

    // acceptance model: mirrors only the externally visible busy window
    always @(posedge clk) begin
        cyc++;
        prev_start = Start;
        if (rst) begin
            run_left = 0;
            sb.delete();
        end else if (run_left > 0) run_left--;
        else if (Start) begin
            sb.push_back(model(A, B, SignedMode, B == 0 ? cyc : cyc + 4));
            run_left = B == 0 ? 0 : 4;
        end
    end

    always @(negedge clk) begin
        if (!rst && cyc > 0) begin
            chk("busy", Busy, run_left > 0);
            if (Done && (!prev_done || prev_start)) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    held = sb.pop_front();
                    chk("latency", cyc, held.due);
                    chk("quotient", Quotient, held.q);
                    chk("remainder", Remainder, held.r);
                    chk("divzero", DivZero, held.dz);
                    chk("overflow", Overflow, held.ov);
                end
            end else if (Done) begin
                chk("hold_q", Quotient, held.q);
                chk("hold_r", Remainder, held.r);
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("missed_done", 0, 1);
                void'(sb.pop_front());
            end
        end
        prev_done = Done;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [3:0] a, input logic [3:0] b, input logic s);
        Start = 1;
        A = a;
        B = b;
        SignedMode = s;
        tick();
        Start = 0;
        A = 4'($urandom);
        B = 4'($urandom);
        SignedMode = 1'($urandom);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_q"}, Quotient, 0);
        chk({nm, "_r"}, Remainder, 0);
        chk({nm, "_flags"}, {Busy, Done, DivZero, Overflow}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        chk_zero("reset");
        rst = 0;
        go(13, 4, 0); repeat (6) tick();
        go(9, 2, 1); repeat (6) tick();
        go(7, 14, 1); repeat (6) tick();
        go(8, 15, 1); repeat (6) tick();
        go(8, 15, 0); repeat (6) tick();
        go(9, 0, 0);
        go(15, 3, 0); repeat (6) tick();
        go(13, 4, 0);
        tick();
        Start = 1; A = 6; B = 2;
        tick();
        Start = 0;
        repeat (6) tick();
        Start = 1;
        for (int i = 0; i < 30; i++) begin
            A = 4'($urandom);
            B = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            SignedMode = 1'($urandom);
            tick();
        end
        Start = 0;
        repeat (6) tick();
        go(13, 4, 0);
        tick();
        rst = 1;
        tick();
        chk_zero("mid_reset");
        rst = 0;
        go(14, 3, 0); repeat (6) tick();
        for (int i = 0; i < 200; i++) begin
            go(4'($urandom), ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 6)) tick();
        end
        repeat (10) tick();
        chk("queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
